// File: rtl/be_stage_queue.sv
// In-order stage queue: up to WR_LANES compacted pushes per cycle, one show-ahead pop per cycle.
// Optional zero-latency empty-queue bypass when QU_STAGE_QUEUE_BYPASS_EN is defined.
module be_stage_queue #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int WR_LANES  = 2,
    parameter int AFULL_LVL = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [WR_LANES-1:0]          in_valid,
    input  logic [WR_LANES*DATA_W-1:0]   in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         ovf_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   lane_data [WR_LANES];
    logic [PTR_W-1:0]    slot [WR_LANES];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [WR_LANES-1:0] store_lane;
    logic                any_valid;
    logic                push_ok;
    logic                pop;
    logic                ovf_evt;
    int                  npush;

    // Modulo-DEPTH add; inc never exceeds DEPTH so one conditional subtract suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int inc);
        int sum;
        sum = int'(ptr) + inc;
        if (sum >= DEPTH)
            sum = sum - DEPTH;
        return PTR_W'(sum);
    endfunction

    for (genvar gi = 0; gi < WR_LANES; gi++) begin : g_lane
        assign lane_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end

    assign any_valid   = |in_valid;
    assign in_ready    = (int'(count) <= (DEPTH - WR_LANES));
    assign almost_full = (int'(count) >= AFULL_LVL);
    assign push_ok     = in_ready && any_valid && !flush;
    assign pop         = (count != '0) && out_ready && !flush;
    assign ovf_evt     = any_valid && !in_ready && !flush;

`ifdef QU_STAGE_QUEUE_BYPASS_EN
    logic [WR_LANES-1:0] byp_mask;
    logic                byp_active;
    logic                byp_take;

    // One-hot of the lowest valid lane.
    assign byp_mask   = in_valid & (~in_valid + WR_LANES'(1));
    assign byp_active = (count == '0) && !flush && any_valid;
    assign byp_take   = byp_active && out_ready;
    assign store_lane = byp_take ? (in_valid & ~byp_mask) : in_valid;

    always_comb begin
        out_valid = (count != '0) || byp_active;
        out_data  = '0;
        if (count != '0) begin
            out_data = mem[rd_ptr];
        end else if (byp_active) begin
            for (int i = 0; i < WR_LANES; i++) begin
                if (byp_mask[i])
                    out_data = lane_data[i];
            end
        end
    end
`else
    assign store_lane = in_valid;
    assign out_valid  = (count != '0);
    assign out_data   = (count != '0) ? mem[rd_ptr] : '0;
`endif

    // Compaction: each stored lane takes the next slot after the lanes below it.
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < WR_LANES; i++) begin
            slot[i] = ptr_add(wr_ptr, k);
            if (store_lane[i])
                k = k + 1;
        end
        npush = push_ok ? k : 0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_LANES; i++) begin
            if (push_ok && store_lane[i])
                mem[slot[i]] <= lane_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= ptr_add(rd_ptr, 1);
            wr_ptr <= ptr_add(wr_ptr, npush);
            count  <= CNT_W'(int'(count) + npush - (pop ? 1 : 0));
            if (ovf_evt)
                ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_be_stage_queue.sv
// Randomised scoreboard bench for be_stage_queue: a 4x2 instance plus a 3-deep single-lane instance.
module tb_be_stage_queue;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int WL = 2;
    localparam int AF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n;
    logic                       flush;
    logic [WL-1:0]              in_valid;
    logic [WL*DW-1:0]           in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [DW-1:0]              out_data;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       almost_full;
    logic                       ovf_err;

    logic        flush3;
    logic [0:0]  in_valid3;
    logic [DW-1:0] in_data3;
    logic        in_ready3;
    logic        out_valid3;
    logic [DW-1:0] out_data3;
    logic        out_ready3;
    logic [1:0]  count3;
    logic        almost_full3;
    logic        ovf_err3;

    be_stage_queue #(.DATA_W(DW), .DEPTH(DEPTH), .WR_LANES(WL), .AFULL_LVL(AF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .almost_full(almost_full), .ovf_err(ovf_err)
    );

    be_stage_queue #(.DATA_W(DW), .DEPTH(3), .WR_LANES(1), .AFULL_LVL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready3),
        .count(count3), .almost_full(almost_full3), .ovf_err(ovf_err3)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: the expected contents as a plain queue plus a sticky overflow bit.
    logic [DW-1:0] exp_q[$];
    int   exp_count = 0;
    logic exp_ov = 1'b0;
    logic exp_ovf = 1'b0;
    logic m_ovf = 1'b0;
    logic mon_en = 1'b0;

    task automatic cycle(input logic [WL-1:0] v, input logic [WL*DW-1:0] d, input logic rdy, input logic fl);
        @(posedge clk); #1;
        in_valid = v; in_data = d; out_ready = rdy; flush = fl;
        mon_en = 1'b1;
        exp_count = exp_q.size();
        exp_ovf = m_ovf;
        exp_ov = (exp_count != 0);
`ifdef QU_STAGE_QUEUE_BYPASS_EN
        if (exp_count == 0 && !fl && v != '0) exp_ov = 1'b1;
`endif
        if (fl) exp_q.delete();
        else if (v != '0) begin
            if (DEPTH - exp_count >= WL) begin
                for (int i = 0; i < WL; i++)
                    if (v[i]) exp_q.push_back(d[i*DW +: DW]);
            end else m_ovf = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 64'(count), 64'(exp_count));
            chk("in_ready", 64'(in_ready), 64'((DEPTH - exp_count) >= WL));
            chk("almost_full", 64'(almost_full), 64'(exp_count >= AF));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("ovf_err", 64'(ovf_err), 64'(exp_ovf));
            if (exp_ov && !flush && exp_q.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(exp_q[0]));
                if (out_ready) begin
                    $display("q4 pop data=%h count=%0d", out_data, count);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    logic [DW-1:0] exp3[$];
    int   exp3_count = 0;
    logic exp3_ov = 1'b0;
    logic exp3_ovf = 1'b0;
    logic m3_ovf = 1'b0;
    logic mon3_en = 1'b0;

    task automatic cycle3(input logic v, input logic [DW-1:0] d, input logic rdy);
        @(posedge clk); #1;
        in_valid3 = v; in_data3 = d; out_ready3 = rdy;
        mon3_en = 1'b1;
        exp3_count = exp3.size();
        exp3_ovf = m3_ovf;
        exp3_ov = (exp3_count != 0);
`ifdef QU_STAGE_QUEUE_BYPASS_EN
        if (exp3_count == 0 && v) exp3_ov = 1'b1;
`endif
        if (v) begin
            if (3 - exp3_count >= 1) exp3.push_back(d);
            else m3_ovf = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon3_en) begin
            chk("q3_count", 64'(count3), 64'(exp3_count));
            chk("q3_in_ready", 64'(in_ready3), 64'(exp3_count < 3));
            chk("q3_almost_full", 64'(almost_full3), 64'(exp3_count >= 3));
            chk("q3_out_valid", 64'(out_valid3), 64'(exp3_ov));
            chk("q3_ovf_err", 64'(ovf_err3), 64'(exp3_ovf));
            if (exp3_ov && exp3.size() != 0) begin
                chk("q3_out_data", 64'(out_data3), 64'(exp3[0]));
                if (out_ready3) begin
                    $display("q3 pop data=%h count=%0d", out_data3, count3);
                    void'(exp3.pop_front());
                end
            end
        end
    end

    initial begin
        logic [WL-1:0]    rv;
        logic [WL*DW-1:0] rd;
        rst_n = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        flush3 = 1'b0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_ovf_err", 64'(ovf_err), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Full fill then in-order drain.
        cycle(2'b11, {32'h22, 32'h11}, 1'b0, 1'b0);
        cycle(2'b11, {32'h44, 32'h33}, 1'b0, 1'b0);
        cycle(2'b00, '0, 1'b0, 1'b0);
        repeat (5) cycle(2'b00, '0, 1'b1, 1'b0);

        // Sparse lane.
        cycle(2'b10, {32'hAB, 32'h0}, 1'b0, 1'b0);
        cycle(2'b00, '0, 1'b1, 1'b0);

        // Simultaneous push and pop at count=2.
        cycle(2'b11, {32'h2, 32'h1}, 1'b0, 1'b0);
        cycle(2'b01, {32'h0, 32'h3}, 1'b1, 1'b0);
        cycle(2'b11, {32'h5, 32'h4}, 1'b1, 1'b0);
        cycle(2'b00, '0, 1'b0, 1'b0);
        repeat (4) cycle(2'b00, '0, 1'b1, 1'b0);

        // Flush with a same-cycle push.
        cycle(2'b11, {32'h7, 32'h6}, 1'b0, 1'b0);
        cycle(2'b11, {32'h9, 32'h8}, 1'b1, 1'b1);
        cycle(2'b00, '0, 1'b0, 1'b0);

        // Overflow at count=4; flag survives a flush.
        cycle(2'b11, {32'hA2, 32'hA1}, 1'b0, 1'b0);
        cycle(2'b11, {32'hA4, 32'hA3}, 1'b0, 1'b0);
        cycle(2'b01, {32'h0, 32'hEE}, 1'b0, 1'b0);
        cycle(2'b00, '0, 1'b0, 1'b0);
        cycle(2'b00, '0, 1'b0, 1'b1);
        cycle(2'b11, {32'hB2, 32'hB1}, 1'b0, 1'b0);
        cycle(2'b01, {32'h0, 32'hB3}, 1'b0, 1'b0);
        cycle(2'b00, '0, 1'b0, 1'b0);

        // Mid-operation reset at count=3.
        @(negedge clk); #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_ovf_err", 64'(ovf_err), 64'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

`ifdef QU_STAGE_QUEUE_BYPASS_EN
        cycle(2'b01, {32'h0, 32'h5A}, 1'b1, 1'b0);
        cycle(2'b00, '0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 400; n++) begin
            rv = WL'($urandom_range(0, 3));
            rd = {$urandom(), $urandom()};
            cycle(rv, rd, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        for (int n = 0; n < 8 && exp_q.size() != 0; n++)
            cycle(2'b00, '0, 1'b1, 1'b0);
        cycle(2'b00, '0, 1'b1, 1'b0);
        mon_en = 1'b0;

        // Non-power-of-two wrap: 3 deep, single lane.
        for (int i = 0; i < 10; i++)
            cycle3(1'b1, DW'(i), 1'b1);
        for (int n = 0; n < 150; n++)
            cycle3(($urandom_range(0, 2) != 0), $urandom(), ($urandom_range(0, 1) == 1));
        for (int n = 0; n < 6; n++)
            cycle3(1'b0, '0, 1'b1);
        @(posedge clk);
        mon3_en = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
